// File: rtl/rf_op_pkg.sv
// Shared opcode and FSM state definitions for the register-file operation engine.
// Shift opcodes are only legal when RF_OP_SHIFT_EN is defined.
package rf_op_pkg;

    typedef enum logic [3:0] {
        OP_MOV = 4'd0,
        OP_ADD = 4'd1,
        OP_SUB = 4'd2,
        OP_AND = 4'd3,
        OP_OR  = 4'd4,
        OP_XOR = 4'd5,
        OP_LDI = 4'd6,
        OP_NOP = 4'd7
    } op_e;

    localparam logic [3:0] OP_SHL = 4'd8;
    localparam logic [3:0] OP_SHR = 4'd9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_EXEC,
        ST_WB,
        ST_RESP
    } state_e;

endpackage

// File: rtl/rf_op_alu.sv
// Combinational ALU for rf_op_engine: result, carry/borrow and illegal-opcode flag.
// Build option RF_OP_SHIFT_EN enables the SHL/SHR opcodes.
module rf_op_alu
    import rf_op_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] imm_i,
    output logic [WIDTH-1:0] result_o,
    output logic             carry_o,
    output logic             illegal_o
);

`ifdef RF_OP_SHIFT_EN
    localparam int SHW = $clog2(WIDTH);
`endif

    always_comb begin
        result_o  = '0;
        carry_o   = 1'b0;
        illegal_o = 1'b0;
        case (op_i)
            OP_MOV: result_o = a_i;
            OP_ADD: {carry_o, result_o} = {1'b0, a_i} + {1'b0, b_i};
            // The extra top bit of the widened difference is the unsigned borrow.
            OP_SUB: {carry_o, result_o} = {1'b0, a_i} - {1'b0, b_i};
            OP_AND: result_o = a_i & b_i;
            OP_OR:  result_o = a_i | b_i;
            OP_XOR: result_o = a_i ^ b_i;
            OP_LDI: result_o = imm_i;
            OP_NOP: result_o = '0;
`ifdef RF_OP_SHIFT_EN
            OP_SHL: result_o = a_i << b_i[SHW-1:0];
            OP_SHR: result_o = a_i >> b_i[SHW-1:0];
`endif
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/rf_op_engine.sv
// Command-driven master for a 2-read/1-write register bank: read, execute, write back, respond.
// Build option RF_OP_SHIFT_EN (passed through to rf_op_alu) enables SHL/SHR.
module rf_op_engine
    import rf_op_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [AW-1:0]    cmd_rd,
    input  logic [AW-1:0]    cmd_rs1,
    input  logic [AW-1:0]    cmd_rs2,
    input  logic [WIDTH-1:0] cmd_imm,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_zero,
    output logic             rsp_carry,
    output logic             rsp_err,
    output logic             we,
    output logic [AW-1:0]    waddr,
    output logic [WIDTH-1:0] wdata,
    output logic [AW-1:0]    raddr_a,
    input  logic [WIDTH-1:0] rdata_a,
    output logic [AW-1:0]    raddr_b,
    input  logic [WIDTH-1:0] rdata_b
);

    state_e           state_q, state_d;
    logic [3:0]       op_q;
    logic [AW-1:0]    rd_q, raddrA_q, raddrB_q, waddr_q;
    logic [WIDTH-1:0] imm_q, opA_q, opB_q, result_q, wdata_q;
    logic             carry_q, zero_q, err_q, we_q, rspValid_q, cmdReady_q;
    logic [WIDTH-1:0] aluResult;
    logic             aluCarry, aluIllegal;

    rf_op_alu #(.WIDTH(WIDTH)) u_alu (
        .op_i      (op_q),
        .a_i       (opA_q),
        .b_i       (opB_q),
        .imm_i     (imm_q),
        .result_o  (aluResult),
        .carry_o   (aluCarry),
        .illegal_o (aluIllegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (cmd_valid) state_d = ST_READ;
            ST_READ: state_d = ST_EXEC;
            ST_EXEC: state_d = (aluIllegal || op_q == OP_NOP) ? ST_RESP : ST_WB;
            ST_WB:   state_d = ST_RESP;
            ST_RESP: if (rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake and write strobes are registered from the next state so every output is a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmdReady_q <= 1'b1;
            rspValid_q <= 1'b0;
            we_q       <= 1'b0;
            op_q       <= '0;
            rd_q       <= '0;
            imm_q      <= '0;
            raddrA_q   <= '0;
            raddrB_q   <= '0;
            opA_q      <= '0;
            opB_q      <= '0;
            result_q   <= '0;
            carry_q    <= 1'b0;
            zero_q     <= 1'b0;
            err_q      <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
        end else begin
            cmdReady_q <= (state_d == ST_IDLE);
            rspValid_q <= (state_d == ST_RESP);
            we_q       <= (state_d == ST_WB);
            if (state_q == ST_IDLE && cmd_valid) begin
                op_q     <= cmd_op;
                rd_q     <= cmd_rd;
                imm_q    <= cmd_imm;
                raddrA_q <= cmd_rs1;
                raddrB_q <= cmd_rs2;
            end
            if (state_q == ST_READ) begin
                opA_q <= rdata_a;
                opB_q <= rdata_b;
            end
            if (state_q == ST_EXEC) begin
                result_q <= aluResult;
                carry_q  <= aluCarry;
                zero_q   <= !aluIllegal && (aluResult == '0);
                err_q    <= aluIllegal;
                waddr_q  <= rd_q;
                wdata_q  <= aluResult;
            end
        end
    end

    assign cmd_ready = cmdReady_q;
    assign rsp_valid = rspValid_q;
    assign rsp_data  = result_q;
    assign rsp_zero  = zero_q;
    assign rsp_carry = carry_q;
    assign rsp_err   = err_q;
    assign we        = we_q;
    assign waddr     = waddr_q;
    assign wdata     = wdata_q;
    assign raddr_a   = raddrA_q;
    assign raddr_b   = raddrB_q;

endmodule
